// File: rtl/xbus_decoder.sv
// xbus_decoder: address decoder, read mux, per-slot software reset and
// unmapped-access error capture between the xctrl data bus and N_SLOTS peripherals.
module xbus_decoder #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int N_SLOTS  = 8,
    parameter int SLOT_AW  = 2,
    parameter int BASE     = 'h100,
    parameter int RST_LEN  = 4,
    parameter int READ_REG = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      data_sel,
    input  logic                      data_we,
    input  logic [ADDR_W-1:0]         data_addr,
    input  logic [DATA_W-1:0]         data_to_wr,
    output logic [DATA_W-1:0]         data_to_rd,
    output logic [N_SLOTS-1:0]        slot_sel,
    output logic                      slot_we,
    output logic [SLOT_AW-1:0]        slot_addr,
    input  logic [N_SLOTS*DATA_W-1:0] slot_rdata,
    output logic [N_SLOTS-1:0]        slot_rst
);

    localparam int IDX_W = ADDR_W - SLOT_AW;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

    logic [ADDR_W-1:0]  off;
    logic               in_range;
    logic [IDX_W-1:0]   idx;
    logic [SLOT_AW-1:0] word;
    logic [N_SLOTS-1:0] hit;
    logic               ctrl_hit;
    logic               unmapped;
    logic               rstctl_wr;
    logic               status_wr;
    logic               fault;

    logic [7:0]         rcnt [N_SLOTS];
    logic [N_SLOTS-1:0] rst_mask;
    logic               err;
    logic [7:0]         err_cnt;
    logic [ADDR_W-1:0]  fault_addr;
    logic [15:0]        status_word;

    logic [DATA_W-1:0]  rd_comb;
    logic [DATA_W-1:0]  rd_data_p1;

    // Write-data bits above the slot count carry no RSTCTL meaning.
    logic               unused_wr_bits;
    assign unused_wr_bits = ^data_to_wr[DATA_W-1:N_SLOTS];

    // Address arithmetic: offset is only meaningful when data_addr >= BASE,
    // so in_range gates every hit and the subtraction never wraps into a slot.
    assign off      = data_addr - BASE_A;
    assign in_range = (data_addr >= BASE_A);
    assign idx      = off[ADDR_W-1:SLOT_AW];
    assign word     = off[SLOT_AW-1:0];
    assign ctrl_hit = in_range && (idx == IDX_W'(N_SLOTS));
    assign unmapped = !(|hit) && !ctrl_hit;

    assign rstctl_wr = data_sel && data_we && ctrl_hit && (word == SLOT_AW'(0));
    assign status_wr = data_sel && data_we && ctrl_hit && (word == SLOT_AW'(1));
    assign fault     = data_sel && unmapped;

    assign slot_sel    = data_sel ? hit : '0;
    assign slot_we     = data_we;
    assign slot_addr   = word;
    assign slot_rst    = {N_SLOTS{rst}} | rst_mask;
    assign status_word = {err_cnt, 7'b0, err};

    // Per-slot hit decode and mask of slots currently held in software reset.
    always_comb begin
        hit      = '0;
        rst_mask = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            hit[i]      = in_range && (idx == IDX_W'(i));
            rst_mask[i] = (rcnt[i] != 8'd0);
        end
    end

    // Read mux: addressed slot or control register; zero when idle or unmapped.
    always_comb begin
        rd_comb = '0;
        if (data_sel) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (hit[i]) rd_comb = slot_rdata[i*DATA_W +: DATA_W];
            end
            if (ctrl_hit) begin
                case (word)
                    SLOT_AW'(0): rd_comb = DATA_W'(rst_mask);
                    SLOT_AW'(1): rd_comb = DATA_W'(status_word);
                    SLOT_AW'(2): rd_comb = DATA_W'(fault_addr);
                    default:     rd_comb = '0;
                endcase
            end
        end
    end

    // Software reset counters: a RSTCTL write (re)loads, otherwise count down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SLOTS; i++) rcnt[i] <= 8'd0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (rstctl_wr && data_to_wr[i])
                    rcnt[i] <= 8'(RST_LEN);
                else if (rcnt[i] != 8'd0)
                    rcnt[i] <= rcnt[i] - 8'd1;
            end
        end
    end

    // Error capture: sticky flag, saturating count, last faulting address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err        <= 1'b0;
            err_cnt    <= 8'd0;
            fault_addr <= '0;
        end else if (fault) begin
            err        <= 1'b1;
            fault_addr <= data_addr;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end else if (status_wr) begin
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end
    end

    // Registered read stage: capture on reads only, hold between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data_p1 <= '0;
        else if (data_sel && !data_we)
            rd_data_p1 <= rd_comb;
    end

    assign data_to_rd = (READ_REG != 0) ? rd_data_p1 : rd_comb;

endmodule

// File: tb/tb_xbus_decoder.sv
// tb_xbus_decoder: directed checks of decode, read paths, software reset and error capture.
module tb_xbus_decoder;

    logic         clk = 1'b0;
    logic         rst;
    logic         data_sel;
    logic         data_we;
    logic [11:0]  data_addr;
    logic [31:0]  data_to_wr;
    logic [255:0] slot_rdata;
    logic [31:0]  rd0, rd1;
    logic [7:0]   sel0, sel1, srst0, srst1;
    logic         we0, we1;
    logic [1:0]   sa0, sa1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    xbus_decoder u0 (
        .clk(clk), .rst(rst), .data_sel(data_sel), .data_we(data_we),
        .data_addr(data_addr), .data_to_wr(data_to_wr), .data_to_rd(rd0),
        .slot_sel(sel0), .slot_we(we0), .slot_addr(sa0),
        .slot_rdata(slot_rdata), .slot_rst(srst0)
    );

    xbus_decoder #(.READ_REG(1)) u1 (
        .clk(clk), .rst(rst), .data_sel(data_sel), .data_we(data_we),
        .data_addr(data_addr), .data_to_wr(data_to_wr), .data_to_rd(rd1),
        .slot_sel(sel1), .slot_we(we1), .slot_addr(sa1),
        .slot_rdata(slot_rdata), .slot_rst(srst1)
    );

    task automatic drive(input logic sel, input logic we, input logic [11:0] addr,
                         input logic [31:0] wdata);
        data_sel   = sel;
        data_we    = we;
        data_addr  = addr;
        data_to_wr = wdata;
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 12'h000, 32'h0);
        #2;
        vectors++;
        if (srst0 !== 8'hFF) begin miscompares++; $display("FAIL reset_slot_rst: got %h expected ff", srst0); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        vectors++;
        if (srst0 !== 8'h00) begin miscompares++; $display("FAIL release_slot_rst: got %h expected 00", srst0); end
        vectors++;
        if (rd1 !== 32'h0) begin miscompares++; $display("FAIL reset_reg_rd: got %h expected 0", rd1); end
        vectors++;
        if (sel0 !== 8'h00) begin miscompares++; $display("FAIL reset_slot_sel: got %h expected 00", sel0); end
    endtask

    task automatic test_registered_read();
        step();
        drive(1, 0, 12'h10C, 32'h0);
        #1;
        vectors++;
        if (rd1 !== 32'h0) begin miscompares++; $display("FAIL regrd_access_cycle: got %h expected 0", rd1); end
        vectors++;
        if (rd0 !== 32'h1234) begin miscompares++; $display("FAIL comb_rd_slot3: got %h expected 1234", rd0); end
        step();
        drive(0, 0, 12'h10C, 32'h0);
        #1;
        vectors++;
        if (rd1 !== 32'h1234) begin miscompares++; $display("FAIL regrd_next_cycle: got %h expected 1234", rd1); end
        vectors++;
        if (rd0 !== 32'h0) begin miscompares++; $display("FAIL comb_rd_idle: got %h expected 0", rd0); end
        step();
        step();
        vectors++;
        if (rd1 !== 32'h1234) begin miscompares++; $display("FAIL regrd_hold: got %h expected 1234", rd1); end
    endtask

    task automatic test_comb_read();
        drive(1, 0, 12'h105, 32'h0);
        #1;
        vectors++;
        if (sel0 !== 8'h02) begin miscompares++; $display("FAIL comb_sel_105: got %h expected 02", sel0); end
        vectors++;
        if (sa0 !== 2'd1) begin miscompares++; $display("FAIL comb_addr_105: got %h expected 1", sa0); end
        vectors++;
        if (rd0 !== 32'hCAFE0001) begin miscompares++; $display("FAIL comb_rd_105: got %h expected cafe0001", rd0); end
        drive(1, 1, 12'h106, 32'h0);
        #1;
        vectors++;
        if (we0 !== 1'b1 || sa0 !== 2'd2) begin miscompares++; $display("FAIL slot_we_addr: got %b/%h expected 1/2", we0, sa0); end
        drive(0, 0, 12'h105, 32'h0);
        #1;
        vectors++;
        if (sel0 !== 8'h00 || rd0 !== 32'h0) begin miscompares++; $display("FAIL sel_low: got %h/%h expected 00/0", sel0, rd0); end
        step();
    endtask

    task automatic test_rstctl();
        drive(1, 1, 12'h120, 32'h0000_0005);
        #1;
        vectors++;
        if (srst0 !== 8'h00) begin miscompares++; $display("FAIL rstctl_write_cycle: got %h expected 00", srst0); end
        step();
        drive(0, 0, 12'h000, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            vectors++;
            if (srst0 !== 8'h05) begin miscompares++; $display("FAIL rstctl_pulse_c%0d: got %h expected 05", c, srst0); end
            step();
        end
        vectors++;
        if (srst0 !== 8'h00) begin miscompares++; $display("FAIL rstctl_pulse_end: got %h expected 00", srst0); end

        // bits above N_SLOTS have no effect
        drive(1, 1, 12'h120, 32'hFFFF_FF00);
        step();
        drive(0, 0, 12'h000, 32'h0);
        vectors++;
        if (srst0 !== 8'h00) begin miscompares++; $display("FAIL rstctl_high_bits: got %h expected 00", srst0); end

        // extend slot 0 by rewriting in its second pulse cycle
        drive(1, 1, 12'h120, 32'h0000_0001);
        step();
        drive(0, 0, 12'h000, 32'h0);
        vectors++;
        if (srst0 !== 8'h01) begin miscompares++; $display("FAIL extend_c1: got %h expected 01", srst0); end
        step();
        drive(1, 1, 12'h120, 32'h0000_0001);
        vectors++;
        if (srst0 !== 8'h01) begin miscompares++; $display("FAIL extend_c2: got %h expected 01", srst0); end
        step();
        drive(1, 0, 12'h120, 32'h0);
        #1;
        vectors++;
        if (rd0 !== 32'h1) begin miscompares++; $display("FAIL rstctl_read_mask: got %h expected 1", rd0); end
        step();
        drive(0, 0, 12'h000, 32'h0);
        vectors++;
        if (rd1 !== 32'h1) begin miscompares++; $display("FAIL rstctl_read_mask_reg: got %h expected 1", rd1); end
        for (int c = 4; c <= 6; c++) begin
            vectors++;
            if (srst0 !== 8'h01) begin miscompares++; $display("FAIL extend_c%0d: got %h expected 01", c, srst0); end
            step();
        end
        vectors++;
        if (srst0 !== 8'h00) begin miscompares++; $display("FAIL extend_end: got %h expected 00", srst0); end
    endtask

    task automatic test_errors();
        drive(1, 0, 12'h0FF, 32'h0); step();
        drive(1, 0, 12'h124, 32'h0); step();
        drive(1, 0, 12'h200, 32'h0); step();
        drive(1, 0, 12'h121, 32'h0);
        #1;
        vectors++;
        if (rd0 !== 32'h0301) begin miscompares++; $display("FAIL status_three: got %h expected 00000301", rd0); end
        step();
        drive(1, 0, 12'h122, 32'h0);
        #1;
        vectors++;
        if (rd0 !== 32'h200) begin miscompares++; $display("FAIL fault_addr: got %h expected 00000200", rd0); end
        step();
        drive(1, 1, 12'h121, 32'h0);
        step();
        drive(1, 0, 12'h121, 32'h0);
        #1;
        vectors++;
        if (rd0 !== 32'h0) begin miscompares++; $display("FAIL status_cleared: got %h expected 0", rd0); end
        step();
        drive(1, 0, 12'h300, 32'h0);
        repeat (300) step();
        drive(1, 0, 12'h121, 32'h0);
        #1;
        vectors++;
        if (rd0 !== 32'hFF01) begin miscompares++; $display("FAIL status_saturate: got %h expected 0000ff01", rd0); end
        step();
        drive(1, 1, 12'h121, 32'h0);
        step();
    endtask

    task automatic test_boundaries();
        drive(1, 0, 12'h11F, 32'h0);
        #1;
        vectors++;
        if (sel0 !== 8'h80 || sa0 !== 2'd3) begin miscompares++; $display("FAIL last_slot_sel: got %h/%h expected 80/3", sel0, sa0); end
        vectors++;
        if (rd0 !== 32'hA000_0007) begin miscompares++; $display("FAIL last_slot_rd: got %h expected a0000007", rd0); end
        step();
        drive(1, 0, 12'h123, 32'h0);
        #1;
        vectors++;
        if (rd0 !== 32'h0 || sel0 !== 8'h00) begin miscompares++; $display("FAIL ctrl_word3: got %h/%h expected 0/00", rd0, sel0); end
        step();
        drive(1, 0, 12'h121, 32'h0);
        #1;
        vectors++;
        if (rd0 !== 32'h0) begin miscompares++; $display("FAIL ctrl_word3_no_err: got %h expected 0", rd0); end
        step();
        drive(1, 0, 12'h0FF, 32'h0);
        #1;
        vectors++;
        if (sel0 !== 8'h00 || rd0 !== 32'h0) begin miscompares++; $display("FAIL below_base: got %h/%h expected 00/0", sel0, rd0); end
        step();
        drive(1, 0, 12'h124, 32'h0);
        #1;
        vectors++;
        if (sel0 !== 8'h00 || rd0 !== 32'h0) begin miscompares++; $display("FAIL after_ctrl: got %h/%h expected 00/0", sel0, rd0); end
        step();
        drive(1, 0, 12'h121, 32'h0);
        #1;
        vectors++;
        if (rd0 !== 32'h0201) begin miscompares++; $display("FAIL boundary_status: got %h expected 00000201", rd0); end
        step();
        drive(1, 0, 12'h122, 32'h0);
        #1;
        vectors++;
        if (rd0 !== 32'h124) begin miscompares++; $display("FAIL boundary_fault: got %h expected 00000124", rd0); end
        step();
        drive(1, 0, 12'h121, 32'h0);
        step();
        drive(0, 0, 12'h000, 32'h0);
    endtask

    task automatic test_reset_mid_pulse();
        drive(1, 1, 12'h120, 32'h0000_00FF);
        step();
        drive(0, 0, 12'h000, 32'h0);
        vectors++;
        if (srst0 !== 8'hFF) begin miscompares++; $display("FAIL pre_rst_pulse: got %h expected ff", srst0); end
        vectors++;
        if (rd1 !== 32'h0201) begin miscompares++; $display("FAIL pre_rst_reg_rd: got %h expected 00000201", rd1); end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (rd1 !== 32'h0) begin miscompares++; $display("FAIL async_rst_reg_rd: got %h expected 0", rd1); end
        #1 rst = 1'b0;
        #1;
        vectors++;
        if (srst0 !== 8'h00) begin miscompares++; $display("FAIL post_rst_slot_rst: got %h expected 00", srst0); end
        step();
        drive(1, 0, 12'h121, 32'h0);
        #1;
        vectors++;
        if (rd0 !== 32'h0) begin miscompares++; $display("FAIL post_rst_status: got %h expected 0", rd0); end
        step();
        drive(1, 0, 12'h122, 32'h0);
        #1;
        vectors++;
        if (rd0 !== 32'h0) begin miscompares++; $display("FAIL post_rst_fault: got %h expected 0", rd0); end
        step();
        drive(0, 0, 12'h000, 32'h0);
        vectors++;
        if (srst0 !== 8'h00) begin miscompares++; $display("FAIL post_rst_idle: got %h expected 00", srst0); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) slot_rdata[i*32 +: 32] = 32'hA000_0000 | 32'(i);
        slot_rdata[1*32 +: 32] = 32'hCAFE_0001;
        slot_rdata[3*32 +: 32] = 32'h0000_1234;
        test_reset();
        test_registered_read();
        test_comb_read();
        test_rstctl();
        test_errors();
        test_boundaries();
        test_reset_mid_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
